pong_game_ctrl: RTL and testbench

Game-level controller that consumes the per-frame hit/miss event pulses from the single-player pong graphics/physics block. It returns the score, the remaining-ball count, the game-over indication and a 16-bit random value for serve direction. It sequences new game, play, re-serve delay and game over, and tells the physics block when to run and when to re-serve.

---
 rtl/pong_pkg.sv | 17 +
 rtl/pong_game_ctrl_if.sv | 25 ++
 rtl/pong_lfsr16.sv | 19 +
 rtl/pong_game_ctrl.sv | 143 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared constants and state encoding for the single-player pong game blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [11:0] FRAME_TICK_X = 12'd0;
  localparam logic [11:0] FRAME_TICK_Y = 12'd500;

  localparam logic [3:0] WIN_SCORE_DEF  = 4'd12;
  localparam logic [1:0] INIT_BALLS_DEF = 2'd3;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and the physics/display side.
interface pong_game_ctrl_if;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic        start;
  logic        hit;
  logic        miss;
  logic [3:0]  score;
  logic [1:0]  ball;
  logic [15:0] rng;
  logic        play_en;
  logic        new_ball;
  logic        over;
  logic [1:0]  state;

  modport master (
    output pixel_x, pixel_y, start, hit, miss,
    input  score, ball, rng, play_en, new_ball, over, state
  );

  modport slave (
    input  pixel_x, pixel_y, start, hit, miss,
    output score, ball, rng, play_en, new_ball, over, state
  );
endinterface

// File: rtl/pong_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every clock.
module pong_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= SEED;
    else      q <= {q[14:0], fb};
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: score/ball bookkeeping, serve delay and game-over timing.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [1:0]  INIT_BALLS   = INIT_BALLS_DEF,
  parameter logic [3:0]  WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned DELAY_FRAMES = 120,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  pong_game_ctrl_if.slave bus
);

  localparam logic [7:0] DELAY_LAST = 8'(DELAY_FRAMES - 1);

  state_t     st;
  logic [3:0] score_q;
  logic [1:0] ball_q;
  logic       play_en_q;
  logic       new_ball_q;
  logic       over_q;
  logic [7:0] cnt;
  logic       start_r, start_p;
  logic       hit_r, hit_p;
  logic       miss_r, miss_p;

  logic frame_tick;
  logic start_edge, hit_edge, miss_edge;

  assign frame_tick = (bus.pixel_x == FRAME_TICK_X) && (bus.pixel_y == FRAME_TICK_Y);
  assign start_edge = start_r & ~start_p;
  assign hit_edge   = hit_r & ~hit_p;
  assign miss_edge  = miss_r & ~miss_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r <= 1'b0;
      start_p <= 1'b0;
      hit_r   <= 1'b0;
      hit_p   <= 1'b0;
      miss_r  <= 1'b0;
      miss_p  <= 1'b0;
    end else begin
      start_r <= bus.start;
      start_p <= start_r;
      hit_r   <= bus.hit;
      hit_p   <= hit_r;
      miss_r  <= bus.miss;
      miss_p  <= miss_r;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= ST_IDLE;
      score_q    <= '0;
      ball_q     <= INIT_BALLS;
      play_en_q  <= 1'b0;
      new_ball_q <= 1'b0;
      over_q     <= 1'b0;
      cnt        <= '0;
    end else begin
      new_ball_q <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          play_en_q <= 1'b0;
          if (start_edge) begin
            st         <= ST_PLAY;
            score_q    <= '0;
            ball_q     <= INIT_BALLS;
            new_ball_q <= 1'b1;
            play_en_q  <= 1'b1;
          end
        end
        ST_PLAY: begin
          play_en_q <= 1'b1;
          // A simultaneous hit is dropped: the miss wins.
          if (miss_edge) begin
            ball_q    <= ball_q - 2'd1;
            cnt       <= '0;
            play_en_q <= 1'b0;
            if (ball_q == 2'd1) begin
              st     <= ST_OVER;
              over_q <= 1'b1;
            end else begin
              st <= ST_NEWBALL;
            end
          end else if (hit_edge) begin
            score_q <= score_q + 4'd1;
            if (score_q + 4'd1 == WIN_SCORE) begin
              st        <= ST_OVER;
              over_q    <= 1'b1;
              play_en_q <= 1'b0;
              cnt       <= '0;
            end
          end
        end
        ST_NEWBALL: begin
          play_en_q <= 1'b0;
          if (frame_tick) begin
            if (cnt == DELAY_LAST) begin
              st         <= ST_PLAY;
              new_ball_q <= 1'b1;
              play_en_q  <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_OVER: begin
          play_en_q <= 1'b0;
          over_q    <= 1'b1;
          if (frame_tick) begin
            if (cnt == DELAY_LAST) begin
              st     <= ST_IDLE;
              over_q <= 1'b0;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  pong_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (bus.rng)
  );

  assign bus.score    = score_q;
  assign bus.ball     = ball_q;
  assign bus.play_en  = play_en_q;
  assign bus.new_ball = new_ball_q;
  assign bus.over     = over_q | (ball_q == 2'd0) | (score_q >= WIN_SCORE);
  assign bus.state    = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for the pong game controller (DELAY_FRAMES=4).
module tb_pong_game_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .INIT_BALLS   (2'd3),
    .WIN_SCORE    (4'd12),
    .DELAY_FRAMES (4),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic pulse_hit();
    bus.hit = 1'b1; step(1); bus.hit = 1'b0; step(2);
  endtask

  task automatic pulse_miss();
    bus.miss = 1'b1; step(1); bus.miss = 1'b0; step(2);
  endtask

  task automatic frame_tick();
    bus.pixel_x = 12'd0; bus.pixel_y = 12'd500; step(1);
    bus.pixel_y = 12'd0; step(1);
  endtask

  task automatic press_start();
    bus.start = 1'b1; step(2); bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] m;
    logic [15:0] prev;
    int          bad;
    rst = 1'b0;
    step(3);
    chk("reset_state", 16'(bus.state), 16'd0);
    chk("reset_score", 16'(bus.score), 16'd0);
    chk("reset_ball", 16'(bus.ball), 16'd3);
    chk("reset_play_en", 16'(bus.play_en), 16'd0);
    chk("reset_new_ball", 16'(bus.new_ball), 16'd0);
    chk("reset_over", 16'(bus.over), 16'd0);
    chk("reset_rng", bus.rng, 16'hACE1);
    rst = 1'b1;
    #1;
    chk("rng_release", bus.rng, 16'hACE1);
    step(1);
    chk("rng_step1", bus.rng, 16'h59C3);
    step(1);
    chk("rng_step2", bus.rng, 16'hB387);
    for (int i = 0; i < 10; i++) frame_tick();
    chk("idle_state", 16'(bus.state), 16'd0);
    chk("idle_play_en", 16'(bus.play_en), 16'd0);
    m = bus.rng;
    bad = 0;
    for (int i = 0; i < 70000; i++) begin
      prev = m;
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      step(1);
      if (bus.rng === prev || bus.rng === 16'h0 || bus.rng !== m) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rng_run: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_start();
    int nb;
    bus.start = 1'b1;
    step(1);
    chk("start_not_yet", 16'(bus.state), 16'd0);
    step(1);
    chk("start_state", 16'(bus.state), 16'd1);
    chk("start_play_en", 16'(bus.play_en), 16'd1);
    chk("start_new_ball", 16'(bus.new_ball), 16'd1);
    chk("start_score", 16'(bus.score), 16'd0);
    chk("start_ball", 16'(bus.ball), 16'd3);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.new_ball === 1'b1) nb++;
    end
    bus.start = 1'b0;
    chk("start_hold_new_ball", 16'(nb), 16'd0);
    chk("start_hold_state", 16'(bus.state), 16'd1);
  endtask

  task automatic test_hits();
    for (int i = 0; i < 3; i++) pulse_hit();
    chk("hits_three", 16'(bus.score), 16'd3);
    bus.hit = 1'b1;
    step(50);
    bus.hit = 1'b0;
    step(2);
    chk("hit_held", 16'(bus.score), 16'd4);
  endtask

  task automatic test_miss_newball();
    pulse_miss();
    chk("miss_ball", 16'(bus.ball), 16'd2);
    chk("miss_state", 16'(bus.state), 16'd2);
    chk("miss_play_en", 16'(bus.play_en), 16'd0);
    pulse_hit();
    pulse_hit();
    chk("newball_hit_ignored", 16'(bus.score), 16'd4);
    for (int i = 0; i < 3; i++) frame_tick();
    chk("newball_after3", 16'(bus.state), 16'd2);
    bus.pixel_x = 12'd0; bus.pixel_y = 12'd500; step(1);
    bus.pixel_y = 12'd0;
    chk("newball_tick4_state", 16'(bus.state), 16'd1);
    chk("newball_tick4_pulse", 16'(bus.new_ball), 16'd1);
    step(1);
    chk("newball_pulse_end", 16'(bus.new_ball), 16'd0);
  endtask

  task automatic test_hit_miss_same();
    pulse_hit();
    chk("score_five", 16'(bus.score), 16'd5);
    bus.hit = 1'b1; bus.miss = 1'b1; step(1);
    bus.hit = 1'b0; bus.miss = 1'b0; step(2);
    chk("both_score", 16'(bus.score), 16'd5);
    chk("both_ball", 16'(bus.ball), 16'd1);
    chk("both_state", 16'(bus.state), 16'd2);
    for (int i = 0; i < 4; i++) frame_tick();
    chk("both_back_play", 16'(bus.state), 16'd1);
  endtask

  task automatic test_win();
    for (int i = 0; i < 6; i++) pulse_hit();
    chk("score_eleven", 16'(bus.score), 16'd11);
    chk("eleven_state", 16'(bus.state), 16'd1);
    chk("eleven_over", 16'(bus.over), 16'd0);
    pulse_hit();
    chk("win_score", 16'(bus.score), 16'd12);
    chk("win_over", 16'(bus.over), 16'd1);
    chk("win_state", 16'(bus.state), 16'd3);
    chk("win_play_en", 16'(bus.play_en), 16'd0);
    for (int i = 0; i < 3; i++) frame_tick();
    chk("win_still_over", 16'(bus.state), 16'd3);
    frame_tick();
    chk("win_idle", 16'(bus.state), 16'd0);
    chk("win_score_held", 16'(bus.score), 16'd12);
    press_start();
    chk("restart_state", 16'(bus.state), 16'd1);
    chk("restart_score", 16'(bus.score), 16'd0);
    chk("restart_ball", 16'(bus.ball), 16'd3);
    chk("restart_over", 16'(bus.over), 16'd0);
  endtask

  task automatic test_out_of_balls();
    pulse_miss();
    for (int i = 0; i < 4; i++) frame_tick();
    pulse_miss();
    chk("oob_ball1", 16'(bus.ball), 16'd1);
    for (int i = 0; i < 4; i++) frame_tick();
    pulse_miss();
    chk("oob_ball0", 16'(bus.ball), 16'd0);
    chk("oob_over", 16'(bus.over), 16'd1);
    chk("oob_state", 16'(bus.state), 16'd3);
    pulse_hit();
    chk("oob_hit_ignored", 16'(bus.score), 16'd0);
    press_start();
    step(1);
    chk("oob_start_ignored", 16'(bus.state), 16'd3);
    for (int i = 0; i < 4; i++) frame_tick();
    chk("oob_idle", 16'(bus.state), 16'd0);
    chk("oob_ball_held", 16'(bus.ball), 16'd0);
    press_start();
    chk("oob_restart", 16'(bus.state), 16'd1);
  endtask

  task automatic test_reset_mid();
    pulse_hit();
    chk("mid_score", 16'(bus.score), 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 16'(bus.state), 16'd0);
    chk("mid_rst_score", 16'(bus.score), 16'd0);
    chk("mid_rst_ball", 16'(bus.ball), 16'd3);
    chk("mid_rst_play_en", 16'(bus.play_en), 16'd0);
    chk("mid_rst_rng", bus.rng, 16'hACE1);
    step(2);
    rst = 1'b1;
    step(2);
    chk("mid_rel_state", 16'(bus.state), 16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.pixel_x = 12'd0;
    bus.pixel_y = 12'd0;
    bus.start = 1'b0;
    bus.hit = 1'b0;
    bus.miss = 1'b0;
    test_reset();
    test_start();
    test_hits();
    test_miss_newball();
    test_hit_miss_same();
    test_win();
    test_out_of_balls();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
